// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU BIST sequencer: opcodes, FSM states,
// vector geometry, MISR constants and the golden ALU function.
package alu_bist_pkg;

    localparam int DATA_W    = 4;
    localparam int VEC_COUNT = 1024;
    localparam int IDX_W     = 10;
    localparam int CNT_W     = 11;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } bist_state_e;

    // Returns {carry, result}; for SUB the carry is the borrow (a < b).
    function automatic logic [DATA_W:0] alu_ref(input alu_op_e op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [DATA_W:0] r;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {(a < b), a - b};
            OP_AND:  r = {1'b0, a & b};
            default: r = {1'b0, a | b};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_bist_misr.sv
// 16-bit multiple-input signature register used when ALU_BIST_MISR_EN is defined;
// clr loads the seed, en shifts and absorbs one data word.
module alu_bist_misr
    import alu_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] data_in,
    output logic [15:0] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ data_in;
        end
    end

endmodule

// File: rtl/alu_bist_seq.sv
// Exhaustive stimulus/check engine for the 4-bit ALU: sweeps all 1024 (op, A, B) vectors.
// Define ALU_BIST_MISR_EN to add the misr_sig signature output.
module alu_bist_seq
    import alu_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              first_fail_vld,
    output logic [IDX_W-1:0]  first_fail_idx
`ifdef ALU_BIST_MISR_EN
    ,
    output logic [15:0]       misr_sig
`endif
);

    localparam int WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    bist_state_e       state, next_state;
    logic [IDX_W-1:0]  vec_idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              start_ok;
    logic              wait_last;
    logic              last_vec;
    logic              mismatch;
    logic [DATA_W:0]   golden;

    assign start_ok  = ena && start && (state == ST_IDLE || state == ST_DONE);
    assign wait_last = (wait_cnt == WAIT_W'(SETTLE_CYCLES - 1));
    assign last_vec  = (vec_idx == IDX_W'(VEC_COUNT - 1));
    assign golden    = alu_ref(alu_op_e'(alu_op), alu_a, alu_b);
    assign mismatch  = ({alu_carry, alu_result} != golden);

    assign busy = (state == ST_DRIVE) || (state == ST_WAIT) || (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done && (err_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE,
            ST_DONE:  if (start_ok) next_state = ST_DRIVE;
            ST_DRIVE: next_state = ST_WAIT;
            ST_WAIT:  if (wait_last) next_state = ST_CHECK;
            ST_CHECK: next_state = last_vec ? ST_DONE : ST_DRIVE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Operands are decoded from the index so that A and B count down within each op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx        <= '0;
            wait_cnt       <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_op         <= '0;
            err_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else if (ena) begin
            case (state)
                ST_IDLE,
                ST_DONE: begin
                    if (start_ok) begin
                        vec_idx        <= '0;
                        err_cnt        <= '0;
                        first_fail_vld <= 1'b0;
                        first_fail_idx <= '0;
                    end
                end
                ST_DRIVE: begin
                    alu_op   <= vec_idx[9:8];
                    alu_a    <= ~vec_idx[7:4];
                    alu_b    <= ~vec_idx[3:0];
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (!first_fail_vld) begin
                            first_fail_vld <= 1'b1;
                            first_fail_idx <= vec_idx;
                        end
                    end
                    if (!last_vec) vec_idx <= vec_idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_BIST_MISR_EN
    alu_bist_misr u_misr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (ena && (state == ST_CHECK)),
        .clr     (start_ok),
        .data_in ({11'b0, alu_carry, alu_result}),
        .sig     (misr_sig)
    );
`endif

endmodule

// File: tb/tb_alu_bist_seq.sv
// Scoreboard bench for alu_bist_seq: a faultable ALU model feeds the DUT, a reference
// sweep predicts each run's results and a monitor checks them when done rises.
module tb_alu_bist_seq;

    localparam int SETTLE     = 1;
    localparam int RUN_CYCLES = 1024 * (SETTLE + 2);

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena   = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  alu_result;
    logic        alu_carry;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [1:0]  alu_op;
    logic        busy;
    logic        done;
    logic        pass;
    logic [10:0] err_cnt;
    logic        first_fail_vld;
    logic [9:0]  first_fail_idx;
`ifdef ALU_BIST_MISR_EN
    logic [15:0] misr_sig;
`endif

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          fault_mode   = 0;
    int          fault_idx    = 0;
    logic [4:0]  fault_mask   = 5'd0;
    logic [4:0]  alu_out;

    typedef struct {
        int          err;
        int          ffv;
        int          ffi;
        int          pass;
        int          cycles;
        logic [15:0] misr;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_bist_seq #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .start          (start),
        .alu_result     (alu_result),
        .alu_carry      (alu_carry),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_op         (alu_op),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_fail_vld (first_fail_vld),
        .first_fail_idx (first_fail_idx)
`ifdef ALU_BIST_MISR_EN
        ,
        .misr_sig       (misr_sig)
`endif
    );

    // Plain-arithmetic ALU: returns carry*16 + result.
    function automatic logic [4:0] golden(int op, int a, int b);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = (a < b) ? 16 + (a - b + 16) : (a - b);
            2:       r = a & b;
            default: r = a | b;
        endcase
        return 5'(r);
    endfunction

    // ALU under test: mode 1 ADD 15+15, mode 2 OR 0|0, mode 3 SUB with a<b, mode 4 one random vector.
    function automatic logic [4:0] faulty(int mode, int fidx, logic [4:0] fmask, int op, int a, int b);
        logic [4:0] g;
        int idx;
        g   = golden(op, a, b);
        idx = op * 256 + (15 - a) * 16 + (15 - b);
        case (mode)
            1: if (op == 0 && a == 15 && b == 15) g = g ^ 5'd1;
            2: if (op == 3 && a == 0 && b == 0) g = g ^ 5'd1;
            3: if (op == 1 && a < b) g = g ^ 5'd1;
            4: if (idx == fidx) g = g ^ fmask;
            default: ;
        endcase
        return g;
    endfunction

    function automatic logic [15:0] misr_step(logic [15:0] s, logic [4:0] d);
        logic [15:0] t;
        t = {s[14:0], 1'b0};
        if (s[15]) t = t ^ 16'h1021;
        return t ^ {11'b0, d};
    endfunction

    function automatic exp_t build_expect(int mode, int fidx, logic [4:0] fmask, int extra);
        exp_t       e;
        int         idx;
        logic [4:0] d;
        e.err  = 0;
        e.ffv  = 0;
        e.ffi  = 0;
        e.misr = 16'hFFFF;
        idx    = 0;
        for (int op = 0; op < 4; op++) begin
            for (int a = 15; a >= 0; a--) begin
                for (int b = 15; b >= 0; b--) begin
                    d = faulty(mode, fidx, fmask, op, a, b);
                    if (d != golden(op, a, b)) begin
                        e.err++;
                        if (e.ffv == 0) begin
                            e.ffv = 1;
                            e.ffi = idx;
                        end
                    end
                    e.misr = misr_step(e.misr, d);
                    idx++;
                end
            end
        end
        e.pass   = (e.err == 0) ? 1 : 0;
        e.cycles = RUN_CYCLES + extra;
        return e;
    endfunction

    assign alu_out = faulty(fault_mode, fault_idx, fault_mask, int'(alu_op), int'(alu_a), int'(alu_b));
    assign {alu_carry, alu_result} = alu_out;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int mode, input int fidx, input logic [4:0] fmask,
                                 input int extra, input bit expect_done);
        @(negedge clk);
        fault_mode = mode;
        fault_idx  = fidx;
        fault_mask = fmask;
        if (expect_done) sb_q.push_back(build_expect(mode, fidx, fmask, extra));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < RUN_CYCLES + 500; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput({name, "_completed"}, int'(ok), 1);
        if (!ok) sb_q.delete();
    endtask

    task automatic waitVector(input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < RUN_CYCLES + 100; i++) begin
            @(negedge clk);
            if (int'(alu_op) == v / 256 && int'(alu_a) == 15 - (v % 256) / 16 &&
                int'(alu_b) == 15 - (v % 16)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic checkZeroOutputs(input string name);
        checkOutput({name, "_alu_a"}, int'(alu_a), 0);
        checkOutput({name, "_alu_b"}, int'(alu_b), 0);
        checkOutput({name, "_alu_op"}, int'(alu_op), 0);
        checkOutput({name, "_busy"}, int'(busy), 0);
        checkOutput({name, "_done"}, int'(done), 0);
        checkOutput({name, "_pass"}, int'(pass), 0);
        checkOutput({name, "_err_cnt"}, int'(err_cnt), 0);
        checkOutput({name, "_ffv"}, int'(first_fail_vld), 0);
        checkOutput({name, "_ffi"}, int'(first_fail_idx), 0);
`ifdef ALU_BIST_MISR_EN
        checkOutput({name, "_misr"}, int'(misr_sig), 0);
`endif
    endtask

    // Monitor: measures busy-to-done latency and checks the run results against the queue head.
    initial begin
        int   cyc;
        int   busy_start;
        logic busy_d;
        logic done_d;
        exp_t e;
        cyc        = 0;
        busy_start = 0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy && !busy_d) busy_start = cyc;
            if (done && !done_d) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("err_cnt", int'(err_cnt), e.err);
                    checkOutput("first_fail_vld", int'(first_fail_vld), e.ffv);
                    checkOutput("first_fail_idx", int'(first_fail_idx), e.ffi);
                    checkOutput("pass", int'(pass), e.pass);
                    checkOutput("run_cycles", cyc - busy_start, e.cycles);
                    checkOutput("busy_at_done", int'(busy), 0);
                    checkOutput("last_op", int'(alu_op), 3);
                    checkOutput("last_a", int'(alu_a), 0);
                    checkOutput("last_b", int'(alu_b), 0);
`ifdef ALU_BIST_MISR_EN
                    checkOutput("misr_sig", int'(misr_sig), int'(e.misr));
`endif
                end
            end
            busy_d = busy;
            done_d = done;
        end
    end

    initial begin
        #(80000 * 10);
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit         ok;
        int         fidx;
        logic [4:0] fmask;

        repeat (3) @(negedge clk);
        checkZeroOutputs("in_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkZeroOutputs("after_reset");

        repeat ($urandom_range(1, 5)) @(negedge clk);
        applyStimulus(0, 0, 5'd0, 0, 1'b1);
        waitDone("clean_run");

        applyStimulus(1, 0, 5'd0, 0, 1'b1);
        waitDone("add_fault");
        applyStimulus(2, 0, 5'd0, 0, 1'b1);
        waitDone("or_fault");
        applyStimulus(3, 0, 5'd0, 0, 1'b1);
        waitDone("sub_fault");

        for (int k = 0; k < 2; k++) begin
            fidx  = int'($urandom_range(0, 1023));
            fmask = 5'($urandom_range(1, 31));
            applyStimulus(4, fidx, fmask, 0, 1'b1);
            waitDone("random_fault");
        end

        // Freeze with ena low while vector 300 (op1, A=13, B=3) is on the bus.
        applyStimulus(0, 0, 5'd0, 50, 1'b1);
        waitVector(300, ok);
        checkOutput("reach_vec300", int'(ok), 1);
        ena = 1'b0;
        repeat (25) @(negedge clk);
        checkOutput("freeze_op", int'(alu_op), 1);
        checkOutput("freeze_a", int'(alu_a), 13);
        checkOutput("freeze_b", int'(alu_b), 3);
        checkOutput("freeze_busy", int'(busy), 1);
        repeat (25) @(negedge clk);
        checkOutput("freeze_a_end", int'(alu_a), 13);
        checkOutput("freeze_done", int'(done), 0);
        ena = 1'b1;
        waitDone("ena_freeze");

        // A start presented while ena is low must not launch a run.
        @(negedge clk);
        ena   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ena   = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("start_with_ena_low", int'(busy), 0);

        // Reset while vector 500 is being exercised aborts the run.
        applyStimulus(0, 0, 5'd0, 0, 1'b0);
        waitVector(500, ok);
        checkOutput("reach_vec500", int'(ok), 1);
        rst_n = 1'b0;
        #1;
        checkZeroOutputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("idle_after_abort", int'(busy), 0);

        // Faulty run, then a fresh clean run with a second start mid-sweep that must be ignored.
        applyStimulus(3, 0, 5'd0, 0, 1'b1);
        waitDone("pre_restart");
        applyStimulus(0, 0, 5'd0, 0, 1'b1);
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("restart_with_busy_start");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
